// File: rtl/axi_write_slave_if.sv
// -----------------------------------------------------------------------------
// axi_write_address_channel
// AXI4 write-address (AW) channel bundle.
//   master modport : drives the AW request fields and awvalid, samples awready
//   slave  modport : samples the AW request fields and awvalid, drives awready
// awuser collapses to a single bit when AXI_AWUSER_WIDTH is 0 so the bundle
// always elaborates; its content is never interpreted by the write slave.
// -----------------------------------------------------------------------------
interface axi_write_address_channel #(
  parameter int AXI_AWID_WIDTH   = 1,
  parameter int AXI_AWADDR_WIDTH = 32,
  parameter int AXI_AWUSER_WIDTH = 0
);
  localparam int UW = (AXI_AWUSER_WIDTH > 0) ? AXI_AWUSER_WIDTH : 1;

  logic [AXI_AWID_WIDTH-1:0]   awid;
  logic [AXI_AWADDR_WIDTH-1:0] awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awlock;
  logic [3:0]                  awcache;
  logic [2:0]                  awprot;
  logic [3:0]                  awqos;
  logic [3:0]                  awregion;
  logic [UW-1:0]               awuser;
  logic                        awvalid;
  logic                        awready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awuser, awvalid,
    input  awready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awuser, awvalid,
    output awready
  );
endinterface

// File: rtl/axi_write_slave.sv
// -----------------------------------------------------------------------------
// axi_write_slave
// AXI4 write endpoint: accepts one AW request at a time, turns every accepted
// W beat into a single-cycle write strobe on a word-addressed memory port and
// answers with one B response.
// Ports:
//   aclk, aresetn         clock, asynchronous active-low reset
//   aw                    AW channel (slave modport)
//   wdata/wstrb/wlast     W payload; wvalid/wready W handshake
//   bid/bresp             B payload; bvalid/bready B handshake
//   mem_we/mem_addr       write strobe and word address
//   mem_wdata/mem_wstrb   W payload passed through to memory
//   mem_ready             memory accepts a write this cycle
// -----------------------------------------------------------------------------
module axi_write_slave #(
  parameter int AXI_AWID_WIDTH   = 1,
  parameter int AXI_AWADDR_WIDTH = 32,
  parameter int AXI_AWUSER_WIDTH = 0,
  parameter int AXI_WDATA_WIDTH  = 32
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  axi_write_address_channel.slave               aw,
  input  logic [AXI_WDATA_WIDTH-1:0]            wdata,
  input  logic [AXI_WDATA_WIDTH/8-1:0]          wstrb,
  input  logic                                  wlast,
  input  logic                                  wvalid,
  output logic                                  wready,
  output logic [AXI_AWID_WIDTH-1:0]             bid,
  output logic [1:0]                            bresp,
  output logic                                  bvalid,
  input  logic                                  bready,
  output logic                                  mem_we,
  output logic [AXI_AWADDR_WIDTH-$clog2(AXI_WDATA_WIDTH/8)-1:0] mem_addr,
  output logic [AXI_WDATA_WIDTH-1:0]            mem_wdata,
  output logic [AXI_WDATA_WIDTH/8-1:0]          mem_wstrb,
  input  logic                                  mem_ready
);
  localparam int NB  = AXI_WDATA_WIDTH / 8;
  localparam int LNB = $clog2(NB);
  localparam int AW  = AXI_AWADDR_WIDTH;
  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} state_e;

  // Request-level errors that suppress every write of the burst.
  function automatic logic aw_bad(input logic [1:0] burst, input logic [2:0] size,
                                  input logic [7:0] len);
    logic bad_len;
    bad_len = (len != 8'd1) && (len != 8'd3) && (len != 8'd7) && (len != 8'd15);
    return (burst == 2'b11) || (size > 3'(LNB)) || ((burst == 2'b10) && bad_len);
  endfunction

  state_e                    state_q, state_d;
  logic                      awready_q, awready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [AXI_AWID_WIDTH-1:0] bid_q, bid_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [2:0]                size_q, size_d;
  logic [1:0]                burst_q, burst_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      sup_q, sup_d;
  logic                      err_q, err_d;

  logic          aw_hs_s, beat_s, mis_s;
  logic [AW-1:0] size_s, incr_s, window_s, base_s, next_addr_s;
  logic          unused_aw_s;

  assign unused_aw_s = ^{aw.awlock, aw.awcache, aw.awprot, aw.awqos, aw.awregion, aw.awuser};

  assign aw.awready = awready_q;
  assign aw_hs_s    = aw.awvalid & awready_q & (state_q == IDLE);
  assign wready     = (state_q == DATA) & mem_ready;
  assign beat_s     = wvalid & wready;
  assign mis_s      = wlast != (cnt_q == 8'd0);
  assign mem_we     = beat_s & ~sup_q;
  assign mem_addr   = addr_q[AW-1:LNB];
  assign mem_wdata  = wdata;
  assign mem_wstrb  = wstrb;
  assign bvalid     = bvalid_q;
  assign bresp      = bresp_q;
  assign bid        = bid_q;

  // Address of the following beat; INCR realigns, WRAP folds back to the window base.
  always_comb begin
    size_s   = ONE_A << size_q;
    incr_s   = (addr_q & ~(size_s - ONE_A)) + size_s;
    window_s = ({{(AW-8){1'b0}}, len_q} + ONE_A) * size_s;
    base_s   = addr_q & ~(window_s - ONE_A);
    case (burst_q)
      2'b01:   next_addr_s = incr_s;
      2'b10:   next_addr_s = (incr_s == base_s + window_s) ? base_s : incr_s;
      default: next_addr_s = addr_q;
    endcase
  end

  // Next-state and register update decisions for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    bid_d    = bid_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;
    sup_d    = sup_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (aw_hs_s) begin
          bid_d   = aw.awid;
          addr_d  = aw.awaddr;
          len_d   = aw.awlen;
          size_d  = aw.awsize;
          burst_d = aw.awburst;
          cnt_d   = aw.awlen;
          sup_d   = aw_bad(aw.awburst, aw.awsize, aw.awlen);
          err_d   = 1'b0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (beat_s) begin
          addr_d = next_addr_s;
          err_d  = err_q | mis_s;
          if (cnt_q == 8'd0) begin
            // Burst length is taken from awlen only; wlast just feeds the error flag.
            state_d  = RESP;
            bvalid_d = 1'b1;
            bresp_d  = (sup_q | err_q | mis_s) ? 2'b10 : 2'b00;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      RESP: begin
        if (bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d  = IDLE;
        bvalid_d = 1'b0;
      end
    endcase
    // awready is registered, so it is high exactly in the cycles spent in IDLE
    // (except the first cycle after reset release).
    awready_d = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      addr_q    <= '0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
      cnt_q     <= 8'd0;
      sup_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      sup_q     <= sup_d;
      err_q     <= err_d;
    end
  end
endmodule
